// File: rtl/spi_sensor_pkg.sv
// Shared types for the SPI sensor poller: controller states, the
// evaluation-mode encoding and the default command byte.
package spi_sensor_pkg;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StWaitPeriod = 3'd1,
    StWrite      = 3'd2,
    StXfer       = 3'd3,
    StRead       = 3'd4,
    StEval       = 3'd5
  } state_t;

  typedef enum logic {
    ModeDelta    = 1'b0,
    ModeCrossing = 1'b1
  } mode_t;

  localparam logic [7:0] DefaultCmdByte = 8'h50;

endpackage

// File: rtl/spi_sensor_poller_if.sv
// Bundle of signals between the poller and the SPI master core.
// "master" is the poller side, "slave" is the SPI master core side.
interface spi_sensor_poller_if #(
  parameter int DataWidth = 8
);

  logic [DataWidth-1:0] SPI_DataIn;
  logic                 SPI_FIFOFull;
  logic                 SPI_FIFOEmpty;
  logic                 SPI_Transmission;
  logic                 SPI_Write;
  logic                 SPI_ReadNext;
  logic [DataWidth-1:0] SPI_DataOut;
  logic                 SPI_CPOL;
  logic                 SPI_CPHA;
  logic                 SPI_LSBFE;

  modport master (
    input  SPI_DataIn, SPI_FIFOFull, SPI_FIFOEmpty, SPI_Transmission,
    output SPI_Write, SPI_ReadNext, SPI_DataOut, SPI_CPOL, SPI_CPHA, SPI_LSBFE
  );

  modport slave (
    output SPI_DataIn, SPI_FIFOFull, SPI_FIFOEmpty, SPI_Transmission,
    input  SPI_Write, SPI_ReadNext, SPI_DataOut, SPI_CPOL, SPI_CPHA, SPI_LSBFE
  );

endinterface

// File: rtl/spi_sensor_xfer.sv
// Byte sequencer for one sensor transfer: pushes the command byte plus
// NumBytes dummy bytes, waits for the SPI core to finish shifting, then
// pops the echo and the data bytes and assembles the value MSB-first.
module spi_sensor_xfer
  import spi_sensor_pkg::*;
#(
  parameter int DataWidth  = 8,
  parameter int NumBytes   = 2,
  parameter int ValueWidth = 16,
  parameter logic [DataWidth-1:0] CmdByte = DataWidth'(DefaultCmdByte)
) (
  input  logic                  Clk_i,
  input  logic                  Reset_i,
  input  logic                  Start_i,
  output logic                  Done_o,
  output logic                  CS_n_o,
  output logic                  Write_o,
  output logic                  ReadNext_o,
  output logic [DataWidth-1:0]  TxData_o,
  input  logic [DataWidth-1:0]  RxData_i,
  input  logic                  FIFOFull_i,
  input  logic                  FIFOEmpty_i,
  input  logic                  Transmission_i,
  output logic [ValueWidth-1:0] Value_o
);

  localparam int IdxW = 3;
  localparam int TotW = NumBytes * DataWidth;

  state_t            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              seen_q, seen_d;
  logic [TotW-1:0]   shift_q, shift_d;

  // Sequencer registers, cleared asynchronously so CS releases at once.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      seen_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seen_q  <= seen_d;
      shift_q <= shift_d;
    end
  end

  // Next-state and strobe logic; a full or empty FIFO simply holds the byte index.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seen_d     = seen_q;
    shift_d    = shift_q;
    Write_o    = 1'b0;
    ReadNext_o = 1'b0;
    TxData_o   = '0;
    Done_o     = 1'b0;
    case (state_q)
      StIdle: begin
        if (Start_i) begin
          state_d = StWrite;
          idx_d   = '0;
          shift_d = '0;
        end
      end
      StWrite: begin
        TxData_o = (idx_q == '0) ? CmdByte : '0;
        if (!FIFOFull_i) begin
          Write_o = 1'b1;
          if (idx_q == IdxW'(NumBytes)) begin
            idx_d   = '0;
            seen_d  = 1'b0;
            state_d = StXfer;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StXfer: begin
        if (Transmission_i) begin
          seen_d = 1'b1;
        end
        if (seen_q && !Transmission_i) begin
          idx_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (!FIFOEmpty_i) begin
          ReadNext_o = 1'b1;
          if (idx_q != '0) begin
            shift_d = shift_q << DataWidth;
            shift_d[DataWidth-1:0] = RxData_i;
          end
          if (idx_q == IdxW'(NumBytes)) begin
            Done_o  = 1'b1;
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign CS_n_o = !((state_q == StWrite) || (state_q == StXfer) || (state_q == StRead));

  if (ValueWidth <= TotW) begin : g_trunc
    assign Value_o = shift_q[ValueWidth-1:0];
  end else begin : g_ext
    assign Value_o = {{(ValueWidth-TotW){1'b0}}, shift_q};
  end

endmodule

// File: rtl/spi_sensor_poller.sv
// Periodic SPI sensor poller: a period timer triggers a transfer, and the
// fresh sample is evaluated in delta or threshold-crossing mode to decide
// whether to update the reported value and pulse the CPU interrupt.
module spi_sensor_poller
  import spi_sensor_pkg::*;
#(
  parameter int DataWidth    = 8,
  parameter int NumBytes     = 2,
  parameter int ValueWidth   = 16,
  parameter int CounterWidth = 32,
  parameter logic [DataWidth-1:0] CmdByte = DataWidth'(DefaultCmdByte)
) (
  input  logic                    Clk_i,
  input  logic                    Reset_i,
  input  logic                    Enable_i,
  input  logic                    ParamMode_i,
  input  logic [ValueWidth-1:0]   ParamThreshold_i,
  input  logic [CounterWidth-1:0] ParamPeriodCounterPreset_i,
  spi_sensor_poller_if.master     spi,
  output logic                    SensorCS_n_o,
  output logic [ValueWidth-1:0]   SensorValue_o,
  output logic                    CpuIntr_o
);

  // StXfer here covers the whole WRITE/XFER/READ sequence run by the sub-module.
  state_t                  state_q, state_d;
  logic [CounterWidth-1:0] count_q, count_d;
  logic                    valid_q, valid_d;
  logic                    abort_q, abort_d;
  logic                    intr_q, intr_d;
  logic [ValueWidth-1:0]   value_q, value_d;
  logic                    start, done;
  logic [ValueWidth-1:0]   rxValue;
  logic [ValueWidth:0]     diff;
  logic                    crossing;
  logic                    report;

  spi_sensor_xfer #(
    .DataWidth (DataWidth),
    .NumBytes  (NumBytes),
    .ValueWidth(ValueWidth),
    .CmdByte   (CmdByte)
  ) u_xfer (
    .Clk_i         (Clk_i),
    .Reset_i       (Reset_i),
    .Start_i       (start),
    .Done_o        (done),
    .CS_n_o        (SensorCS_n_o),
    .Write_o       (spi.SPI_Write),
    .ReadNext_o    (spi.SPI_ReadNext),
    .TxData_o      (spi.SPI_DataOut),
    .RxData_i      (spi.SPI_DataIn),
    .FIFOFull_i    (spi.SPI_FIFOFull),
    .FIFOEmpty_i   (spi.SPI_FIFOEmpty),
    .Transmission_i(spi.SPI_Transmission),
    .Value_o       (rxValue)
  );

  assign spi.SPI_CPOL  = 1'b1;
  assign spi.SPI_CPHA  = 1'b1;
  assign spi.SPI_LSBFE = 1'b0;

  // Report decision for the sample just read, using the mode and threshold seen in EVAL.
  always_comb begin
    diff     = (rxValue >= value_q) ? ({1'b0, rxValue} - {1'b0, value_q})
                                    : ({1'b0, value_q} - {1'b0, rxValue});
    crossing = (mode_t'(ParamMode_i) == ModeCrossing);
    if (crossing) begin
      report = (rxValue > ParamThreshold_i) && (!valid_q || (value_q <= ParamThreshold_i));
    end else begin
      report = !valid_q || (diff > {1'b0, ParamThreshold_i});
    end
  end

  // Controller state, period counter and reported value, all cleared asynchronously.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q <= StIdle;
      count_q <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      intr_q  <= 1'b0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
      intr_q  <= intr_d;
      value_q <= value_d;
    end
  end

  // Next-state logic: timer, transfer hand-off, abort tracking and evaluation.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    valid_d = valid_q;
    abort_d = abort_q;
    intr_d  = 1'b0;
    value_d = value_q;
    start   = 1'b0;
    case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        abort_d = 1'b0;
        if (Enable_i) begin
          count_d = ParamPeriodCounterPreset_i;
          state_d = StWaitPeriod;
        end
      end
      StWaitPeriod: begin
        if (!Enable_i) begin
          state_d = StIdle;
        end else if (count_q == '0) begin
          start   = 1'b1;
          abort_d = 1'b0;
          state_d = StXfer;
        end else begin
          count_d = count_q - CounterWidth'(1);
        end
      end
      StXfer: begin
        if (!Enable_i) begin
          abort_d = 1'b1;
        end
        if (done) begin
          state_d = (abort_q || !Enable_i) ? StIdle : StEval;
        end
      end
      StEval: begin
        if (report) begin
          intr_d  = 1'b1;
          value_d = rxValue;
        end
        if (crossing) begin
          value_d = rxValue;
        end
        valid_d = 1'b1;
        if (Enable_i) begin
          count_d = ParamPeriodCounterPreset_i;
          state_d = StWaitPeriod;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign SensorValue_o = value_q;
  assign CpuIntr_o     = intr_q;

endmodule

// File: tb/tb_spi_sensor_poller.sv
// Self-checking bench for spi_sensor_poller with a behavioural SPI core
// model and a reference model of the delta / crossing reporting rules.
module tb_spi_sensor_poller;

  localparam int NB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        mode;
  logic [15:0] thr;
  logic [31:0] preset;
  logic        csN;
  logic [15:0] value;
  logic        intr;

  int testCount = 0;
  int failCount = 0;

  // SPI core model state
  logic [7:0]  rxq[$];
  logic [7:0]  wrLog[$];
  int          popCount = 0;
  int          wrCount = 0;
  int          txCount = 0;
  int          intrCount = 0;
  logic [15:0] nextSample = 16'h0;
  logic        fifoFull = 1'b0;
  logic        mTrans = 1'b0;
  logic        mEmpty = 1'b1;
  logic [7:0]  mData = 8'h00;
  logic        sWr, sRd;
  logic [7:0]  sWd;

  // Reference model state
  logic [15:0] refValue = 16'h0;
  bit          refValid = 1'b0;

  always #5 clk = ~clk;

  spi_sensor_poller_if #(.DataWidth(8)) spi();

  assign spi.SPI_DataIn       = mData;
  assign spi.SPI_FIFOEmpty    = mEmpty;
  assign spi.SPI_FIFOFull     = fifoFull;
  assign spi.SPI_Transmission = mTrans;

  spi_sensor_poller #(
    .DataWidth(8), .NumBytes(NB), .ValueWidth(16), .CounterWidth(32), .CmdByte(8'h50)
  ) dut (
    .Clk_i                     (clk),
    .Reset_i                   (rst),
    .Enable_i                  (enable),
    .ParamMode_i               (mode),
    .ParamThreshold_i          (thr),
    .ParamPeriodCounterPreset_i(preset),
    .spi                       (spi),
    .SensorCS_n_o              (csN),
    .SensorValue_o             (value),
    .CpuIntr_o                 (intr)
  );

  // SPI core model: strobes sampled just before the edge, effects applied just after it
  always begin
    @(negedge clk);
    #3;
    sWr = spi.SPI_Write;
    sWd = spi.SPI_DataOut;
    sRd = spi.SPI_ReadNext;
    @(posedge clk);
    #1;
    if (rst) begin
      rxq.delete();
      wrCount = 0;
      txCount = 0;
      mTrans  = 1'b0;
    end else begin
      if (sRd && rxq.size() > 0) begin
        void'(rxq.pop_front());
        popCount++;
      end
      if (mTrans) begin
        txCount--;
        if (txCount <= 0) begin
          rxq.push_back(8'hFF);
          rxq.push_back(nextSample[15:8]);
          rxq.push_back(nextSample[7:0]);
          mTrans = 1'b0;
        end
      end
      if (sWr) begin
        wrLog.push_back(sWd);
        wrCount++;
        if (wrCount == NB + 1) begin
          wrCount = 0;
          txCount = 2 + int'($urandom_range(0, 3));
          mTrans  = 1'b1;
        end
      end
    end
    mEmpty = (rxq.size() == 0);
    mData  = mEmpty ? 8'h00 : rxq[0];
  end

  // Interrupt monitor counts high cycles so a stretched pulse shows up as extra reports
  always @(negedge clk) begin
    if (intr === 1'b1) intrCount++;
  end

  // Global time limit
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference rules: delta reports on first sample or |new-old| > thr; crossing
  // always updates and reports on a rising crossing of thr.
  function automatic bit refStep(input logic [15:0] s);
    int d;
    bit irq;
    if (mode == 1'b0) begin
      d = int'(s) - int'(refValue);
      if (d < 0) d = -d;
      irq = !refValid || (d > int'(thr));
      if (irq) refValue = s;
    end else begin
      irq = (s > thr) && (!refValid || (refValue <= thr));
      refValue = s;
    end
    refValid = 1'b1;
    return irq;
  endfunction

  task automatic waitCsLevel(input logic level, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (csN === level) return;
    end
    testCount++;
    failCount++;
    $display("[TB] FAIL cs_wait: SensorCS_n_o never reached %0b within %0d cycles", level, budget);
  endtask

  task automatic runMeasurement(input logic [15:0] s, output int pulses,
                                output logic [15:0] val, output logic [23:0] wrBytes);
    int i0, w0;
    nextSample = s;
    i0 = intrCount;
    w0 = wrLog.size();
    waitCsLevel(1'b0, 200);
    waitCsLevel(1'b1, 200);
    repeat (3) @(negedge clk);
    pulses = intrCount - i0;
    val    = value;
    if (wrLog.size() >= w0 + 3) wrBytes = {wrLog[w0], wrLog[w0+1], wrLog[w0+2]};
    else wrBytes = 24'hDEAD00;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    testCount++;
    if (csN !== 1'b1) begin failCount++; $display("[TB] FAIL reset_cs: got %b want 1", csN); end
    testCount++;
    if ({spi.SPI_Write, spi.SPI_ReadNext, spi.SPI_DataOut, intr, value} !== 27'h0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: wr=%b rd=%b data=%h intr=%b value=%h want all 0",
               spi.SPI_Write, spi.SPI_ReadNext, spi.SPI_DataOut, intr, value);
    end
    testCount++;
    if ({spi.SPI_CPOL, spi.SPI_CPHA, spi.SPI_LSBFE} !== 3'b110) begin
      failCount++;
      $display("[TB] FAIL spi_mode: got %b want 110", {spi.SPI_CPOL, spi.SPI_CPHA, spi.SPI_LSBFE});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_sample;
    int lat, i0, w0;
    logic [23:0] wb;
    mode = 1'b0;
    thr = 16'h0010;
    preset = 32'd3;
    nextSample = 16'h0C80;
    i0 = intrCount;
    w0 = wrLog.size();
    enable = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (csN === 1'b1 && lat < 50);
    testCount++;
    if (lat != 5) begin failCount++; $display("[TB] FAIL wait_latency: got %0d cycles want 5", lat); end
    waitCsLevel(1'b1, 200);
    repeat (3) @(negedge clk);
    void'(refStep(16'h0C80));
    wb = (wrLog.size() >= w0 + 3) ? {wrLog[w0], wrLog[w0+1], wrLog[w0+2]} : 24'hDEAD00;
    testCount++;
    if (wb !== 24'h500000) begin failCount++; $display("[TB] FAIL first_writes: got %h want 500000", wb); end
    testCount++;
    if (value !== 16'h0C80) begin failCount++; $display("[TB] FAIL first_value: got %h want 0c80", value); end
    testCount++;
    if (intrCount - i0 != 1) begin failCount++; $display("[TB] FAIL first_irq: got %0d pulses want 1", intrCount - i0); end
  endtask

  task automatic test_delta;
    int p;
    logic [15:0] v;
    logic [23:0] wb;
    runMeasurement(16'h0C88, p, v, wb);
    void'(refStep(16'h0C88));
    testCount++;
    if (p != 0 || v !== 16'h0C80) begin
      failCount++;
      $display("[TB] FAIL delta_small: got irq=%0d value=%h want irq=0 value=0c80", p, v);
    end
    runMeasurement(16'h0C91, p, v, wb);
    void'(refStep(16'h0C91));
    testCount++;
    if (p != 1 || v !== 16'h0C91) begin
      failCount++;
      $display("[TB] FAIL delta_large: got irq=%0d value=%h want irq=1 value=0c91", p, v);
    end
    testCount++;
    if (wb !== 24'h500000) begin failCount++; $display("[TB] FAIL delta_writes: got %h want 500000", wb); end
  endtask

  task automatic test_crossing;
    logic [15:0] samples[5] = '{16'h0CF0, 16'h0D10, 16'h0D20, 16'h0CF0, 16'h0D05};
    int expIrq[5] = '{0, 1, 0, 0, 1};
    int p;
    logic [15:0] v;
    logic [23:0] wb;
    mode = 1'b1;
    thr = 16'h0D00;
    for (int i = 0; i < 5; i++) begin
      runMeasurement(samples[i], p, v, wb);
      void'(refStep(samples[i]));
      testCount++;
      if (p != expIrq[i] || v !== samples[i]) begin
        failCount++;
        $display("[TB] FAIL crossing_%0d: got irq=%0d value=%h want irq=%0d value=%h",
                 i, p, v, expIrq[i], samples[i]);
      end
    end
  endtask

  task automatic test_random;
    int p;
    logic [15:0] v, s;
    logic [23:0] wb;
    bit irq;
    for (int i = 0; i < 12; i++) begin
      mode = 1'($urandom_range(0, 1));
      if (mode) thr = 16'(32'h4000 + $urandom_range(0, 40) - 20);
      else thr = 16'($urandom_range(0, 40));
      s = 16'(32'h4000 + $urandom_range(0, 96) - 48);
      runMeasurement(s, p, v, wb);
      irq = refStep(s);
      testCount++;
      if (p != int'(irq) || v !== refValue) begin
        failCount++;
        $display("[TB] FAIL random_%0d: mode=%0b thr=%h sample=%h got irq=%0d value=%h want irq=%0d value=%h",
                 i, mode, thr, s, p, v, irq, refValue);
      end
    end
  endtask

  task automatic test_fifo_stall;
    int stallWrites, i0, w0, wsz;
    logic [23:0] wb;
    bit irq;
    mode = 1'b0;
    thr = 16'h0000;
    nextSample = 16'h5A5A;
    i0 = intrCount;
    w0 = wrLog.size();
    waitCsLevel(1'b0, 200);
    fifoFull = 1'b1;
    stallWrites = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (spi.SPI_Write !== 1'b0) stallWrites++;
      @(negedge clk);
    end
    wsz = wrLog.size();
    fifoFull = 1'b0;
    testCount++;
    if (stallWrites != 0 || wsz != w0) begin
      failCount++;
      $display("[TB] FAIL stall_no_write: got %0d strobes, %0d logged want 0", stallWrites, wsz - w0);
    end
    waitCsLevel(1'b1, 200);
    repeat (3) @(negedge clk);
    irq = refStep(16'h5A5A);
    wb = (wrLog.size() >= w0 + 3) ? {wrLog[w0], wrLog[w0+1], wrLog[w0+2]} : 24'hDEAD00;
    testCount++;
    if (wb !== 24'h500000 || wrLog.size() != w0 + 3) begin
      failCount++;
      $display("[TB] FAIL stall_writes: got %h (%0d bytes) want 500000 (3 bytes)", wb, wrLog.size() - w0);
    end
    testCount++;
    if (intrCount - i0 != int'(irq) || value !== refValue) begin
      failCount++;
      $display("[TB] FAIL stall_result: got irq=%0d value=%h want irq=%0d value=%h",
               intrCount - i0, value, irq, refValue);
    end
  endtask

  task automatic test_abort;
    int i0, p0, lows, n;
    logic [15:0] v0;
    nextSample = 16'h1234;
    i0 = intrCount;
    p0 = popCount;
    v0 = value;
    waitCsLevel(1'b0, 200);
    n = 0;
    while (spi.SPI_Transmission !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    waitCsLevel(1'b1, 200);
    repeat (3) @(negedge clk);
    testCount++;
    if (popCount - p0 != 3 || rxq.size() != 0) begin
      failCount++;
      $display("[TB] FAIL abort_reads: got %0d pops, %0d left want 3 pops, 0 left", popCount - p0, rxq.size());
    end
    testCount++;
    if (intrCount != i0 || value !== v0) begin
      failCount++;
      $display("[TB] FAIL abort_report: got irq=%0d value=%h want irq=0 value=%h", intrCount - i0, value, v0);
    end
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (csN !== 1'b1) lows++;
    end
    testCount++;
    if (lows != 0) begin failCount++; $display("[TB] FAIL abort_idle: got %0d cs-low cycles want 0", lows); end
    refValid = 1'b0;
  endtask

  task automatic test_reset_midread;
    int n;
    nextSample = 16'hABCD;
    enable = 1'b1;
    n = 0;
    while (spi.SPI_ReadNext !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    testCount++;
    if (n >= 300) begin failCount++; $display("[TB] FAIL read_wait: got no ReadNext want one within 300 cycles"); end
    rst = 1'b1;
    #1;
    testCount++;
    if (csN !== 1'b1) begin failCount++; $display("[TB] FAIL midread_cs: got %b want 1", csN); end
    testCount++;
    if ({spi.SPI_Write, spi.SPI_ReadNext, spi.SPI_DataOut, intr, value} !== 27'h0) begin
      failCount++;
      $display("[TB] FAIL midread_outputs: wr=%b rd=%b data=%h intr=%b value=%h want all 0",
               spi.SPI_Write, spi.SPI_ReadNext, spi.SPI_DataOut, intr, value);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    refValue = 16'h0;
    refValid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    mode = 1'b0;
    thr = 16'h0;
    preset = 32'd3;
    test_reset;
    test_first_sample;
    test_delta;
    test_crossing;
    test_random;
    test_fifo_stall;
    test_abort;
    test_reset_midread;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/spi_sensor_poller.md
SPI_SENSOR_POLLER -- requirements
Module: spi_sensor_poller

Interface
REQ-001 Parameter DataWidth, default 8: SPI byte width.
REQ-002 Parameter NumBytes, default 2, legal 1..4: data bytes read per measurement after the command byte.
REQ-003 Parameter ValueWidth, default 16: sensor value and threshold width.
REQ-004 Parameter CounterWidth, default 32: period counter width.
REQ-005 Parameter CmdByte, default 8'h50: command byte sent first in every transfer.
REQ-006 Clk_i  in  1  sole clock; all state changes on the rising edge.
REQ-007 Reset_i  in  1  asynchronous, active-high reset.
REQ-008 Enable_i  in  1  high enables periodic polling.
REQ-009 ParamMode_i  in  1  0 = delta mode, 1 = crossing mode.
REQ-010 ParamThreshold_i  in  ValueWidth  delta limit or crossing level.
REQ-011 ParamPeriodCounterPreset_i  in  CounterWidth  idle cycles between measurements.
REQ-012 SPI_Data_i  in  DataWidth  SPI master receive FIFO head.
REQ-013 SPI_FIFOFull_i / SPI_FIFOEmpty_i / SPI_Transmission_i  in  1 each  SPI master status.
REQ-014 SPI_Write_o / SPI_ReadNext_o  out  1 each  one-cycle push/pop strobes.
REQ-015 SPI_Data_o  out  DataWidth  transmit byte.
REQ-016 SPI_CPOL_o=1, SPI_CPHA_o=1, SPI_LSBFE_o=0  out  1 each  constant SPI mode.
REQ-017 SensorCS_n_o  out  1  active-low sensor chip select.
REQ-018 SensorValue_o  out  ValueWidth  last reported value.
REQ-019 CpuIntr_o  out  1  one-cycle report pulse.

Function
REQ-020 States: IDLE, WAIT_PERIOD, WRITE, XFER, READ, EVAL.
REQ-021 IDLE: Enable_i=1 -> load counter with preset -> WAIT_PERIOD; valid flag cleared in IDLE.
REQ-022 WAIT_PERIOD: decrement each cycle; count 0 -> WRITE (preset 0 -> WRITE next cycle); Enable_i=0 -> IDLE.
REQ-023 WRITE: SensorCS_n_o low; push CmdByte then NumBytes bytes of 0x00, one per cycle, SPI_Write_o high only when SPI_FIFOFull_i=0; full stalls, never drops a byte; last push -> XFER.
REQ-024 XFER: wait until SPI_Transmission_i seen high then low -> READ.
REQ-025 READ: pop 1+NumBytes bytes via SPI_ReadNext_o, only when SPI_FIFOEmpty_i=0; command echo discarded; data bytes assembled MSB-first; value = low ValueWidth bits, zero-extended if narrower; then SensorCS_n_o high -> EVAL.
REQ-026 Delta mode: report if valid flag clear or |new-SensorValue_o| > ParamThreshold_i (unsigned, ValueWidth+1-bit difference); report = SensorValue_o<=new and CpuIntr_o high one cycle; set valid flag.
REQ-027 Crossing mode: SensorValue_o<=new every sample; CpuIntr_o only when new > threshold and previous sample <= threshold (first sample after enable treats previous as below).
REQ-028 EVAL -> WAIT_PERIOD (counter reloaded) if Enable_i=1, else IDLE.
REQ-029 Enable_i low in WRITE/XFER/READ: transfer completes, CS released normally, no report, then IDLE.
REQ-030 ParamMode_i and ParamThreshold_i sampled in EVAL only.

Reset
REQ-031 Reset_i high: state IDLE, SensorCS_n_o=1, SPI_Write_o=0, SPI_ReadNext_o=0, SPI_Data_o=0, CpuIntr_o=0, SensorValue_o=0, counter=0, valid flag=0, all immediately without clock.

Structure
REQ-032 Package spi_sensor_pkg holds state enum, mode encodings, default command byte 0x50.
REQ-033 Sub-module spi_sensor_xfer implements WRITE/XFER/READ byte sequencing with start/done handshake; the top holds timer and evaluation.

Verification
REQ-034 Reset mid-idle -> SensorCS_n_o=1, all other outputs 0, no clock needed.
REQ-035 NumBytes=2, preset 3, Enable_i=1 -> after 4 wait cycles writes 0x50,0x00,0x00; SPI model returns 0xFF,0x0C,0x80 -> SensorValue_o=0x0C80, one CpuIntr_o pulse.
REQ-036 Delta mode, threshold 0x0010: next samples 0x0C88 -> no IRQ, value stays 0x0C80; 0x0C91 -> IRQ, value 0x0C91.
REQ-037 Crossing mode, threshold 0x0D00: samples 0x0CF0, 0x0D10, 0x0D20, 0x0CF0, 0x0D05 -> IRQ only on 0x0D10 and 0x0D05.
REQ-038 SPI_FIFOFull_i high 5 cycles during WRITE -> no SPI_Write_o during stall, all 3 bytes still pushed in order.
REQ-039 Enable_i dropped during XFER -> reads complete, CS high, no IRQ, IDLE; Reset_i mid-READ -> CS high at once.
